// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for the multicycle MULT/DIV unit.
//
// Accepts a one-cycle start request and drives the unit's DivMultControl for
// exactly the iteration count of the selected operation. It then captures the
// unit result into the architectural Hi/Lo registers and pulses done. A divide
// by zero is reported as a one-cycle div_zero_exc pulse. The block also
// generates the pipeline stall for MFHI/MFLO and for new requests that arrive
// while the unit is busy.
//
// Optional feature macro: MD_EARLY_DIVZERO_EN
//   defined   : a DIV request with op_b == 0 is rejected in IDLE, and
//               div_zero_exc pulses one cycle later. The unit is never started.
//   undefined : op_b is ignored. Divide by zero is taken from md_divzero
//               after the first active edge.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   request pulse from control (held until accepted)
//   op           in   0 = MULT, 1 = DIV, sampled with start
//   hilo_read    in   control wants Hi or Lo this cycle
//   op_b         in   [31:0] divisor, used only with MD_EARLY_DIVZERO_EN
//   md_hi        in   [31:0] unit Hi output
//   md_lo        in   [31:0] unit Lo output
//   md_divzero   in   unit DivZero flag
//   md_ctrl      out  [1:0] unit DivMultControl: 0 idle, 1 mult, 2 div
//   busy         out  sequencer not idle
//   stall        out  busy & (start | hilo_read), combinational
//   done         out  one-cycle pulse, Hi/Lo updated
//   div_zero_exc out  one-cycle pulse, divide by zero
//   hi           out  [31:0] architectural Hi
//   lo           out  [31:0] architectural Lo
module muldiv_seq #(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic        hilo_read,
  input  logic [31:0] op_b,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        md_divzero,
  output logic [1:0]  md_ctrl,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero_exc,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CAPTURE
  } state_e;

  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_MULT = 2'd1;
  localparam logic [1:0] CTRL_DIV  = 2'd2;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] DZ_COUNT  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              op_q, op_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              early_dz;
  logic [CNT_W-1:0]  last_cnt;

`ifdef MD_EARLY_DIVZERO_EN
  assign early_dz = op & (op_b == '0);
`else
  logic unused_op_b;
  assign early_dz    = 1'b0;
  assign unused_op_b = ^op_b;
`endif

  assign last_cnt = op_q ? DIV_LAST : MULT_LAST;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    ctrl_d  = ctrl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        ctrl_d  = CTRL_IDLE;
        if (start && early_dz) begin
          dz_d = 1'b1;
        end else if (start) begin
          op_d    = op;
          state_d = S_RUN;
          ctrl_d  = op ? CTRL_DIV : CTRL_MULT;
        end
      end
      S_RUN: begin
        count_d = count_q + 1'b1;
        // The unit raises DivZero after its first active edge, so count==1
        // is the first cycle in which the flag is meaningful.
        if (op_q && (count_q == DZ_COUNT) && md_divzero) begin
          state_d = S_IDLE;
          ctrl_d  = CTRL_IDLE;
          count_d = '0;
          dz_d    = 1'b1;
        end else if (count_q == last_cnt) begin
          state_d = S_CAPTURE;
          ctrl_d  = CTRL_IDLE;
          count_d = '0;
        end
      end
      S_CAPTURE: begin
        hi_d    = md_hi;
        lo_d    = md_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ctrl_d  = CTRL_IDLE;
        count_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      op_q    <= 1'b0;
      ctrl_q  <= CTRL_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md_ctrl      = ctrl_q;
  assign busy         = busy_q;
  assign stall        = busy_q & (start | hilo_read);
  assign done         = done_q;
  assign div_zero_exc = dz_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: a behavioural MULT/DIV unit model plus a
// cycle-timeline reference derived from the operation latencies.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        hilo_read = 1'b0;
  logic [31:0] op_b = '0;
  logic [31:0] md_hi = '0;
  logic [31:0] md_lo = '0;
  logic        md_divzero = 1'b0;
  logic [1:0]  md_ctrl;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero_exc;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_seq #(
    .MULT_CYCLES(32),
    .DIV_CYCLES (33),
    .CNT_W      (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .hilo_read   (hilo_read),
    .op_b        (op_b),
    .md_hi       (md_hi),
    .md_lo       (md_lo),
    .md_divzero  (md_divzero),
    .md_ctrl     (md_ctrl),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .div_zero_exc(div_zero_exc),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Unit model: re-initialises on a 0->nonzero control edge, counts active
  // edges, flags divide-by-zero after the first one and writes Hi/Lo on the
  // 32nd (mult) or 33rd (div) active edge.
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  int unsigned act = 0;
  logic [1:0]  prev_ctrl = 2'd0;
  logic [63:0] uprod;

  always @(posedge clk) begin
    if (md_ctrl != 2'd0) begin
      if (prev_ctrl == 2'd0) act = 1;
      else act = act + 1;
      if (act == 1) md_divzero <= (md_ctrl == 2'd2) && (opb == 0);
      if (md_ctrl == 2'd1 && act == 32) begin
        uprod = {32'b0, opa} * {32'b0, opb};
        md_hi <= uprod[63:32];
        md_lo <= uprod[31:0];
      end
      if (md_ctrl == 2'd2 && act == 33 && opb != 0) begin
        md_lo <= opa / opb;
        md_hi <= opa % opb;
      end
    end
    prev_ctrl = md_ctrl;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned op_idx = 0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Runs one operation with start sampled at the end of cycle 0 and checks
  // every output in each following cycle. noise: 0 none, 1 start at cycle 10
  // and hilo_read at cycle 20, 2 random. chain drives the next request in the
  // final (done) cycle; the following call then uses skip0.
  task automatic do_op(input bit o, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned noise, input bit skip0, input bit chain,
                       input bit no, input logic [31:0] na, input logic [31:0] nb);
    int unsigned n;
    int unsigned last;
    bit          dz;
    bit          early;
    logic [1:0]  code;
    logic [31:0] new_hi;
    logic [31:0] new_lo;
    logic [63:0] prod;
    op_idx++;
    n     = o ? 33 : 32;
    code  = o ? 2'd2 : 2'd1;
    dz    = o && (b == 0);
    early = 1'b0;
`ifdef MD_EARLY_DIVZERO_EN
    early = dz;
`endif
    if (o) begin
      new_lo = (b != 0) ? a / b : ref_lo;
      new_hi = (b != 0) ? a % b : ref_hi;
    end else begin
      prod   = {32'b0, a} * {32'b0, b};
      new_hi = prod[63:32];
      new_lo = prod[31:0];
    end
    last = early ? 1 : (dz ? 3 : n + 2);
    if (!skip0) begin
      @(negedge clk);
      opa = a; opb = b; op_b = b; op = o; start = 1'b1; hilo_read = 1'b0;
      #1;
      check($sformatf("op%0d c0 busy", op_idx), busy, 0);
      check($sformatf("op%0d c0 stall", op_idx), stall, 0);
    end
    for (int unsigned c = 1; c <= last; c++) begin
      bit         eb, ed, ez, es;
      logic [1:0] ec;
      if (early) begin
        ec = 2'd0; eb = 1'b0; ed = 1'b0; ez = (c == 1);
      end else if (dz) begin
        ec = (c <= 2) ? code : 2'd0; eb = (c <= 2); ed = 1'b0; ez = (c == 3);
      end else begin
        ec = (c <= n) ? code : 2'd0; eb = (c <= n + 1); ed = (c == n + 2); ez = 1'b0;
      end
      @(negedge clk);
      start = 1'b0;
      hilo_read = 1'b0;
      if (noise == 1) begin
        start = eb && (c == 10);
        hilo_read = (c == 20);
      end else if (noise == 2) begin
        start = eb && ($urandom_range(0, 3) == 0);
        hilo_read = ($urandom_range(0, 2) == 0);
      end
      if (start) op = 1'($urandom_range(0, 1));
      if (chain && c == last) begin
        start = 1'b1; op = no; opa = na; opb = nb; op_b = nb;
      end
      es = eb && (start || hilo_read);
      #1;
      check($sformatf("op%0d c%0d md_ctrl", op_idx, c), md_ctrl, ec);
      check($sformatf("op%0d c%0d busy", op_idx, c), busy, eb);
      check($sformatf("op%0d c%0d stall", op_idx, c), stall, es);
      check($sformatf("op%0d c%0d done", op_idx, c), done, ed);
      check($sformatf("op%0d c%0d div_zero_exc", op_idx, c), div_zero_exc, ez);
      check($sformatf("op%0d c%0d hi", op_idx, c), hi, ed ? new_hi : ref_hi);
      check($sformatf("op%0d c%0d lo", op_idx, c), lo, ed ? new_lo : ref_lo);
    end
    if (!dz) begin
      ref_hi = new_hi;
      ref_lo = new_lo;
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          ro;

    // Power-on reset
    repeat (3) @(negedge clk);
    #1;
    check("rst md_ctrl", md_ctrl, 0);
    check("rst busy", busy, 0);
    check("rst stall", stall, 0);
    check("rst done", done, 0);
    check("rst div_zero_exc", div_zero_exc, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;

    // MULT 6*7 with an ignored start and a hilo_read while busy, then a DIV
    // by zero requested in the done cycle, then DIV 100/7.
    do_op(1'b0, 32'd6, 32'd7, 1, 1'b0, 1'b1, 1'b1, 32'd9, 32'd0);
    do_op(1'b1, 32'd9, 32'd0, 0, 1'b1, 1'b0, 1'b0, '0, '0);
    do_op(1'b1, 32'd100, 32'd7, 0, 1'b0, 1'b0, 1'b0, '0, '0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Randomised operations with random stall stimulus
    for (int i = 0; i < 14; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      do_op(ro, ra, rb, 2, 1'b0, 1'b0, 1'b0, '0, '0);
    end

    // Async reset in cycle 12 of a DIV
    @(negedge clk);
    opa = 32'd100; opb = 32'd7; op_b = 32'd7; op = 1'b1; start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check($sformatf("rdiv c%0d md_ctrl", c), md_ctrl, 2);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid-rst md_ctrl", md_ctrl, 0);
    check("mid-rst busy", busy, 0);
    check("mid-rst hi", hi, 0);
    check("mid-rst lo", lo, 0);
    check("mid-rst done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    ref_hi = '0;
    ref_lo = '0;
    do_op(1'b0, 32'd6, 32'd7, 0, 1'b0, 1'b0, 1'b0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
